// File: rtl/crc_clk_gate_ctrl.sv
// CRC engine clock-gate sequencer: hold-off, 4-phase req/ack gating,
// wake on activity, gate-event counting and handshake timeout flag.
module crc_clk_gate_ctrl #(
    parameter int HOLDOFF_W   = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_crc_idle,
    input  logic                 i_activation_pulse,
    input  logic                 i_force_on,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    input  logic                 i_cg_ack,
    input  logic                 i_timeout_clr,
    output logic                 o_clk_en,
    output logic                 o_cg_req,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_gate_cnt,
    output logic                 o_ack_timeout
);

    localparam logic [2:0] ST_ON       = 3'd0;
    localparam logic [2:0] ST_HOLDOFF  = 3'd1;
    localparam logic [2:0] ST_GATE_REQ = 3'd2;
    localparam logic [2:0] ST_OFF      = 3'd3;
    localparam logic [2:0] ST_WAKE_REQ = 3'd4;

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [HOLDOFF_W-1:0] hold_q;
    logic [TMR_W-1:0]     tmr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 tmo_q;
    logic                 clk_en_q;
    logic                 req_q;
    logic                 clk_en_d;
    logic                 req_d;
    logic                 gate_done;
    logic                 tmo_set;
    logic                 wake;
    logic                 tmr_hit;
    logic                 in_hs_d;

    assign wake    = i_activation_pulse | ~i_crc_idle | i_force_on;
    assign tmr_hit = (tmr_q == TMR_LAST);
    assign in_hs_d = (state_d == ST_GATE_REQ) || (state_d == ST_WAKE_REQ);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_ON;
            clk_en_q <= 1'b1;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_en_d;
            req_q    <= req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_done = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            ST_ON: begin
                if (i_crc_idle && !i_force_on)
                    state_d = (i_holdoff == '0) ? ST_GATE_REQ : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (wake)
                    state_d = ST_ON;
                else if (hold_q == HOLDOFF_W'(1))
                    state_d = ST_GATE_REQ;
            end
            ST_GATE_REQ: begin
                // a same-cycle ack wins; the wake is picked up from OFF
                if (i_cg_ack) begin
                    state_d   = ST_OFF;
                    gate_done = 1'b1;
                end else if (tmr_hit) begin
                    state_d = ST_WAKE_REQ;
                    tmo_set = 1'b1;
                end else if (wake) begin
                    state_d = ST_WAKE_REQ;
                end
            end
            ST_OFF: begin
                if (wake)
                    state_d = ST_WAKE_REQ;
            end
            ST_WAKE_REQ: begin
                if (!i_cg_ack) begin
                    state_d = ST_ON;
                end else if (tmr_hit) begin
                    state_d = ST_ON;
                    tmo_set = 1'b1;
                end
            end
            default: state_d = ST_ON;
        endcase
    end

    always_comb begin
        clk_en_d = 1'b0;
        req_d    = 1'b0;
        case (state_d)
            ST_ON, ST_HOLDOFF: clk_en_d = 1'b1;
            ST_GATE_REQ: begin
                clk_en_d = 1'b1;
                req_d    = 1'b1;
            end
            ST_OFF:  req_d = 1'b1;
            default: begin
                clk_en_d = 1'b0;
                req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold_q <= '0;
            tmr_q  <= '0;
            cnt_q  <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (state_q == ST_ON && state_d == ST_HOLDOFF)
                hold_q <= i_holdoff;
            else if (state_q == ST_HOLDOFF)
                hold_q <= hold_q - HOLDOFF_W'(1);

            if (in_hs_d && state_d == state_q)
                tmr_q <= tmr_q + TMR_W'(1);
            else
                tmr_q <= '0;

            if (gate_done && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);

            if (tmo_set)
                tmo_q <= 1'b1;
            else if (i_timeout_clr)
                tmo_q <= 1'b0;
        end
    end

    assign o_clk_en      = clk_en_q;
    assign o_cg_req      = req_q;
    assign o_state       = state_q;
    assign o_gate_cnt    = cnt_q;
    assign o_ack_timeout = tmo_q;

endmodule

// File: tb/tb_crc_clk_gate_ctrl.sv
// Bench for crc_clk_gate_ctrl: latency arithmetic, counter model,
// timeout and override scenarios with randomized hold-off and ack delay.
module tb_crc_clk_gate_ctrl;

    localparam int HW  = 8;
    localparam int CW  = 4;
    localparam int TMO = 64;

    logic          i_clk;
    logic          i_reset;
    logic          i_crc_idle;
    logic          i_activation_pulse;
    logic          i_force_on;
    logic [HW-1:0] i_holdoff;
    logic          i_cg_ack;
    logic          i_timeout_clr;
    logic          o_clk_en;
    logic          o_cg_req;
    logic [2:0]    o_state;
    logic [CW-1:0] o_gate_cnt;
    logic          o_ack_timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    // clock-gate cell emulation: ack follows req after ack_dly cycles
    logic [15:0] hist = '0;
    int          ack_dly = 1;
    logic        ack_frz = 1'b0;
    logic        ack_val = 1'b0;

    crc_clk_gate_ctrl #(
        .HOLDOFF_W  (HW),
        .CNT_W      (CW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_crc_idle        (i_crc_idle),
        .i_activation_pulse(i_activation_pulse),
        .i_force_on        (i_force_on),
        .i_holdoff         (i_holdoff),
        .i_cg_ack          (i_cg_ack),
        .i_timeout_clr     (i_timeout_clr),
        .o_clk_en          (o_clk_en),
        .o_cg_req          (o_cg_req),
        .o_state           (o_state),
        .o_gate_cnt        (o_gate_cnt),
        .o_ack_timeout     (o_ack_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) hist <= {hist[14:0], o_cg_req};

    always_comb begin
        if (ack_frz) i_cg_ack = ack_val;
        else         i_cg_ack = hist[ack_dly-1];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return (which == 0) ? o_cg_req : o_clk_en;
    endfunction

    task automatic wait_sig(input int which, input logic val,
                            input int max, output int cyc);
        cyc = 0;
        while (sig(which) !== val && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic bump();
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    endtask

    task automatic settle();
        i_crc_idle = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_gate(input int h, input int d);
        int c;
        ack_frz    = 1'b0;
        ack_dly    = d;
        i_holdoff  = HW'(h);
        i_crc_idle = 1'b1;
        wait_sig(0, 1'b1, 300, c);
        chk("gate_req_latency", c, h + 1);
        wait_sig(1, 1'b0, 50, c);
        chk("gate_off_latency", c, d + 1);
        bump();
        chk("gate_cnt", 32'(o_gate_cnt), exp_cnt);
        repeat (6) tick();
        chk("stay_off", 32'(o_state), 3);
    endtask

    task automatic do_wake(input int d);
        int c;
        ack_frz            = 1'b0;
        ack_dly            = d;
        i_crc_idle         = 1'b0;
        i_activation_pulse = 1'b1;
        tick();
        i_activation_pulse = 1'b0;
        chk("wake_state", 32'(o_state), 4);
        chk("wake_req_low", 32'(o_cg_req), 0);
        wait_sig(1, 1'b1, 50, c);
        chk("wake_latency", c, d + 1);
        chk("wake_on", 32'(o_state), 0);
        settle();
    endtask

    initial begin
        int bad;
        i_reset            = 1'b1;
        i_crc_idle         = 1'b0;
        i_activation_pulse = 1'b0;
        i_force_on         = 1'b0;
        i_holdoff          = '0;
        i_timeout_clr      = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        chk("rst_state", 32'(o_state), 0);
        chk("rst_clk_en", 32'(o_clk_en), 1);
        chk("rst_req", 32'(o_cg_req), 0);
        chk("rst_cnt", 32'(o_gate_cnt), 0);
        chk("rst_tmo", 32'(o_ack_timeout), 0);
        settle();

        do_gate(4, 2);
        chk("first_gate_clk_en", 32'(o_clk_en), 0);
        do_wake(3);

        // hold-off aborted by activation pulse in its 5th cycle
        bad = 0;
        i_holdoff  = HW'(10);
        i_crc_idle = 1'b1;
        repeat (5) begin
            tick();
            if (o_state !== 3'd1 || o_cg_req !== 1'b0) bad++;
        end
        i_activation_pulse = 1'b1;
        tick();
        i_activation_pulse = 1'b0;
        i_crc_idle         = 1'b0;
        chk("abort_state", 32'(o_state), 0);
        chk("abort_holdoff_cycles", bad, 0);
        chk("abort_req", 32'(o_cg_req), 0);
        chk("abort_cnt", 32'(o_gate_cnt), exp_cnt);
        settle();

        // gate handshake timeout, zero hold-off
        ack_frz    = 1'b1;
        ack_val    = 1'b0;
        i_holdoff  = '0;
        i_crc_idle = 1'b1;
        tick();
        chk("h0_gate_req", 32'(o_state), 2);
        chk("h0_req", 32'(o_cg_req), 1);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", 32'(o_ack_timeout), 0);
        chk("tmo_still_req", 32'(o_state), 2);
        tick();
        chk("tmo_set", 32'(o_ack_timeout), 1);
        chk("tmo_wake_req", 32'(o_state), 4);
        i_crc_idle = 1'b0;
        tick();
        chk("tmo_on", 32'(o_state), 0);
        chk("tmo_clk_en", 32'(o_clk_en), 1);
        chk("tmo_cnt", 32'(o_gate_cnt), exp_cnt);
        repeat (3) tick();
        chk("tmo_sticky", 32'(o_ack_timeout), 1);
        i_timeout_clr = 1'b1;
        tick();
        i_timeout_clr = 1'b0;
        chk("tmo_clr", 32'(o_ack_timeout), 0);

        // wake handshake timeout; set beats a held clear
        ack_val    = 1'b1;
        i_crc_idle = 1'b1;
        tick();
        tick();
        bump();
        chk("wt_off", 32'(o_state), 3);
        i_crc_idle    = 1'b0;
        i_timeout_clr = 1'b1;
        tick();
        chk("wt_wake_req", 32'(o_state), 4);
        repeat (TMO - 1) tick();
        chk("wt_still", 32'(o_state), 4);
        chk("wt_tmo_low", 32'(o_ack_timeout), 0);
        tick();
        chk("wt_failsafe_on", 32'(o_state), 0);
        chk("wt_set_over_clr", 32'(o_ack_timeout), 1);
        tick();
        i_timeout_clr = 1'b0;
        chk("wt_cleared", 32'(o_ack_timeout), 0);
        ack_val = 1'b0;
        settle();

        // ack and wake in the same cycle
        i_crc_idle = 1'b1;
        tick();
        chk("aw_gate_req", 32'(o_state), 2);
        ack_val    = 1'b1;
        i_crc_idle = 1'b0;
        tick();
        bump();
        chk("aw_off", 32'(o_state), 3);
        chk("aw_cnt", 32'(o_gate_cnt), exp_cnt);
        tick();
        chk("aw_wake_req", 32'(o_state), 4);
        ack_val = 1'b0;
        tick();
        chk("aw_on", 32'(o_state), 0);

        // wake before ack aborts the gate request
        i_crc_idle = 1'b1;
        tick();
        i_crc_idle = 1'b0;
        tick();
        chk("ab_wake_req", 32'(o_state), 4);
        chk("ab_req", 32'(o_cg_req), 0);
        chk("ab_cnt", 32'(o_gate_cnt), exp_cnt);
        tick();
        chk("ab_on", 32'(o_state), 0);
        settle();

        // software override keeps the clock on
        bad = 0;
        i_force_on = 1'b1;
        i_crc_idle = 1'b1;
        i_holdoff  = HW'(3);
        repeat (100) begin
            tick();
            if (o_state !== 3'd0 || o_cg_req !== 1'b0) bad++;
        end
        chk("force_hold_on", bad, 0);
        i_force_on = 1'b0;

        do_gate(2, 1);
        begin
            int c;
            i_force_on = 1'b1;
            tick();
            chk("force_wake", 32'(o_state), 4);
            wait_sig(1, 1'b1, 50, c);
            chk("force_wake_lat", c, 2);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (o_state !== 3'd0) bad++;
        end
        chk("force_stay_on", bad, 0);
        i_force_on = 1'b0;
        settle();

        // randomized gate/wake cycles drive the counter into saturation
        for (int i = 0; i < 18; i++) begin
            do_gate($urandom_range(0, 12), $urandom_range(1, 5));
            do_wake($urandom_range(1, 5));
        end
        chk("cnt_saturated", 32'(o_gate_cnt), 15);

        // asynchronous reset while gated
        do_gate(1, 1);
        @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_state", 32'(o_state), 0);
        chk("arst_clk_en", 32'(o_clk_en), 1);
        chk("arst_req", 32'(o_cg_req), 0);
        chk("arst_cnt", 32'(o_gate_cnt), 0);
        tick();
        i_crc_idle = 1'b0;
        i_reset    = 1'b0;
        tick();
        chk("arst_release", 32'(o_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_clk_gate_ctrl.md
Name: crc_clk_gate_ctrl

Overview:
- Power-sequencing stage directly downstream of the CRC activity filter.
- Consumes the filter's idle level and activation pulse. After a programmable hold-off, requests clock gating of the CRC engine through a 4-phase req/ack handshake with the clock-gate cell, and ungates on any wake event.
- Runs on the always-on clock; the gated clock it controls is downstream of o_clk_en.
- Tracks gating events and flags handshake timeouts for software.

Parameters:
- HOLDOFF_W, 8, width of i_holdoff (hold-off cycles before gating).
- CNT_W, 16, width of the saturating gate-event counter.
- TIMEOUT_CYC, 64, cycles allowed for i_cg_ack to follow o_cg_req before timeout (≥2).

Ports:
- i_clk  in  1  always-on clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_crc_idle  in  1  idle level from activity filter (1 = engine idle).
- i_activation_pulse  in  1  1-cycle wake pulse from activity filter.
- i_force_on  in  1  software override; 1 = never gate, wake if gated.
- i_holdoff  in  HOLDOFF_W  hold-off length in cycles; sampled on entry to HOLDOFF.
- i_cg_ack  in  1  clock-gate acknowledge; follows o_cg_req level.
- i_timeout_clr  in  1  pulse; clears o_ack_timeout.
- o_clk_en  out  1  1 = CRC engine clock running.
- o_cg_req  out  1  1 = gating requested (4-phase level).
- o_state  out  3  current FSM state encoding.
- o_gate_cnt  out  CNT_W  number of completed gate entries, saturating.
- o_ack_timeout  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset values: state ON (0), o_clk_en=1, o_cg_req=0, o_gate_cnt=0, o_ack_timeout=0, hold-off and timeout counters 0. Reset mid-handshake returns to ON regardless of i_cg_ack.
- All outputs are registered Moore decodes of state:
  - o_clk_en=1 in ON, HOLDOFF and GATE_REQ.
  - o_cg_req=1 in GATE_REQ and OFF.
- Wake event: i_activation_pulse | ~i_crc_idle | i_force_on.
- States and transitions:
  - ON (0):
    - i_crc_idle & ~i_force_on & i_holdoff!=0 -> HOLDOFF, counter loaded with i_holdoff.
    - Same condition with i_holdoff==0 -> GATE_REQ directly.
  - HOLDOFF (1):
    - Counter decrements each cycle.
    - Wake event -> ON; this has priority over expiry.
    - Counter==1 with no wake event -> GATE_REQ.
    - Net effect: exactly i_holdoff cycles are spent in HOLDOFF.
  - GATE_REQ (2):
    - i_cg_ack==1 -> OFF; o_gate_cnt += 1, saturating at all-ones.
    - Wake event before ack -> WAKE_REQ (abort; req drops; gate_cnt unchanged).
    - Ack and wake in the same cycle -> OFF; wake is then serviced from OFF next cycle.
  - OFF (3): wake event -> WAKE_REQ.
  - WAKE_REQ (4): i_cg_ack==0 -> ON.
  - Encodings 5-7 are illegal -> ON.
- Handshake timeout:
  - Timer clears on entry to GATE_REQ/WAKE_REQ and increments each cycle in those states.
  - Timer reaching TIMEOUT_CYC-1 without the awaited ack level sets o_ack_timeout.
  - On timeout in GATE_REQ -> WAKE_REQ.
  - On timeout in WAKE_REQ -> ON (fail-safe: clock restored).
- o_ack_timeout stays set until i_timeout_clr. Set has priority over clear in the same cycle.
- i_force_on held high: the FSM stays in ON after any wake sequence completes.
- Latency: wake event in OFF -> o_cg_req low next cycle -> o_clk_en high one cycle after ack observed low.

Test Plan:
- Reset, then i_crc_idle=1, i_holdoff=4, ack mirrors req after 2 cycles -> HOLDOFF for 4 cycles, o_cg_req=1, OFF after ack, o_clk_en=0, o_gate_cnt=1.
- Idle, i_holdoff=10, i_activation_pulse at hold-off cycle 5 -> returns to ON, o_cg_req never asserts, o_gate_cnt=0.
- In OFF, pulse i_activation_pulse; ack drops 3 cycles after req -> WAKE_REQ, then ON, o_clk_en=1 one cycle after ack low.
- GATE_REQ with ack tied 0, TIMEOUT_CYC=64 -> o_ack_timeout=1 after 64 cycles, WAKE_REQ then ON. i_timeout_clr clears the flag.
- i_force_on=1 with i_crc_idle=1 for 100 cycles -> stays ON, o_cg_req=0. i_holdoff=0 with i_force_on=0 -> ON->GATE_REQ in 1 cycle.
- Force o_gate_cnt to all-ones via 2^CNT_W gate cycles (CNT_W=4 build) -> counter saturates at 15. Reset asserted in OFF -> immediate ON, o_clk_en=1.
